face_pos_collector: RTL
=======================

Name: face_pos_collector

Overview:
- Sits directly downstream of the 23x23 max-value/threshold stage.
- Consumes its per-face position pulses (13-bit linear output-map index) and its end-of-frame flag.
- Converts each index to image-pixel (x,y) via a fixed-latency shift-subtract divider.
- Buffers results in a small show-ahead FIFO that the host/overlay logic drains.

Parameters:
- MAP_W, 90: output-map width in entries.
- MAP_H, 90: output-map height; valid indices 0..MAP_W*MAP_H-1.
- SCALE_SHIFT, 2: map-to-image scale, as a left-shift amount.
- OFFSET, 11: added to both scaled coordinates (half of the 23-pixel window).
- IQ_DEPTH, 4: input position queue depth (power of 2).
- DEPTH, 16: result buffer depth (power of 2).

Ports:
- iClk  in  1  system clock.
- iReset  in  1  asynchronous, active-high reset.
- iStart  in  1  one-cycle pulse; clears all state and begins a frame.
- iPos_valid  in  1  one-cycle pulse; iPosition is valid.
- iPosition  in  13  linear map index, row-major.
- iEnd  in  1  one-cycle pulse; upstream has finished the frame.
- iRd  in  1  pop the head result.
- oData  out  32  head result {x[15:0], y[15:0]}; valid when oEmpty=0.
- oEmpty  out  1  result buffer empty.
- oCount  out  log2(DEPTH)+1  number of stored results.
- oBusy  out  1  conversion in progress or input queue non-empty.
- oDone  out  1  frame complete and all conversions written.
- oOverflow  out  1  sticky; a position was dropped.
- oRange_err  out  1  sticky; an index >= MAP_W*MAP_H was received.

Behaviour:
- Reset (iReset=1, asynchronous) and iStart (synchronous, any state, any time including mid-conversion):
  - State to IDLE (reset) or COLLECT (iStart).
  - Both queues flushed; oData=0, oEmpty=1, oCount=0.
  - oBusy, oDone, oOverflow, oRange_err all cleared to 0.
- FSM:
  - IDLE: ignores everything except iStart.
  - COLLECT: input queue non-empty -> DIV. Otherwise, if the end flag is latched -> DONE.
  - DIV: exactly 13 cycles of restoring division of the index by MAP_W. Produces row (quotient) and col (remainder). -> WR.
  - WR: 1 cycle.
    - Computes x = (col<<SCALE_SHIFT)+OFFSET and y = (row<<SCALE_SHIFT)+OFFSET, each zero-extended to 16 bits.
    - Pushes {x,y} into the result buffer; pops the input queue. -> COLLECT.
  - DONE: oDone=1; holds until iStart. Results stay readable.
- Input capture:
  - iPos_valid is accepted in COLLECT, DIV and WR, as long as iEnd has not yet been latched.
  - Range check happens at capture: an index >= MAP_W*MAP_H is not queued and sets oRange_err.
  - Input queue full: the new pulse is dropped and oOverflow is set.
  - iPos_valid in IDLE or DONE: ignored, no flags.
- iEnd handling:
  - Latched in any non-IDLE state.
  - iPos_valid in the same cycle as iEnd is still accepted.
  - Pulses after that cycle are ignored.
  - Pending queue entries are always converted before DONE.
- Latency: iPos_valid sampled at edge E0 with the FSM idle in COLLECT and the queue empty -> result written at edge E15 (oEmpty falls / oCount increments after E15).
- Result buffer full at WR: the result is discarded, oOverflow is set, and the FSM still returns to COLLECT.
- iRd:
  - Pops the head on the next edge when oEmpty=0; ignored when empty.
  - iRd and WR in the same cycle: both occur and oCount is unchanged. This holds even when full, because the pop frees the slot first.
- oData: show-ahead, registered; it is 0 whenever the buffer is empty.
- oBusy = (state is DIV or WR) or input queue non-empty.

Optional Feature:
- DUP_SUPPRESS_EN defined:
  - At WR, a result equal to the most recently written {x,y} in this frame is not pushed.
  - oCount is unchanged, and no overflow is flagged even if the buffer is full.
  - The last-written register is cleared by reset/iStart.
- Undefined: every converted position is pushed.

Test Plan (defaults: MAP_W=90, SCALE_SHIFT=2, OFFSET=11):
- iStart, then iPos_valid with 0, then iEnd -> oEmpty falls after edge E15; oData=0x000B000B; oDone=1 one cycle after WR; iRd -> oEmpty=1, oData=0.
- Positions 181 and 8099, back to back -> reads give 0x000F0013 then 0x016F016F; oCount goes 1 then 2.
- Position 8100 -> not converted; oRange_err=1; oCount=0; iEnd -> oDone=1.
- 6 pulses on consecutive cycles (IQ_DEPTH=4): the 1st enters DIV, the 2nd–5th queue, the 6th is dropped -> oOverflow=1; 5 results stored.
- Fill the buffer to 16, then issue iRd in the same cycle as the 17th WR -> oCount stays 16; no overflow. Repeat without iRd -> oOverflow=1.
- iStart asserted mid-DIV with 3 queued and 2 stored -> next cycle oCount=0, oEmpty=1, oBusy=0, flags clear, state COLLECT. With DUP_SUPPRESS_EN: position 181 twice -> oCount=1.

Source files
------------

// File: rtl/face_pos_collector.sv
// Converts face-position map indices into image (x,y) pairs and buffers them for the host.
// Define DUP_SUPPRESS_EN to skip a result equal to the one most recently written in the frame.
module face_pos_collector #(
  parameter int unsigned MAP_W       = 90,
  parameter int unsigned MAP_H       = 90,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned OFFSET      = 11,
  parameter int unsigned IQ_DEPTH    = 4,
  parameter int unsigned DEPTH       = 16
) (
  input  logic                   iClk,
  input  logic                   iReset,
  input  logic                   iStart,
  input  logic                   iPos_valid,
  input  logic [12:0]            iPosition,
  input  logic                   iEnd,
  input  logic                   iRd,
  output logic [31:0]            oData,
  output logic                   oEmpty,
  output logic [$clog2(DEPTH):0] oCount,
  output logic                   oBusy,
  output logic                   oDone,
  output logic                   oOverflow,
  output logic                   oRange_err
);

  localparam int unsigned IDX_W  = 13;
  localparam int unsigned REM_W  = $clog2(MAP_W) + 1;
  localparam int unsigned STEP_W = $clog2(IDX_W);
  localparam int unsigned IQ_AW  = $clog2(IQ_DEPTH);
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned CNT_W  = AW + 1;
  localparam logic [IDX_W:0]   MAP_SIZE = (IDX_W+1)'(MAP_W * MAP_H);
  localparam logic [REM_W-1:0] DIVISOR  = REM_W'(MAP_W);

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_DIV, S_WR, S_DONE} state_t;
  state_t state;

  logic [IDX_W-1:0]  iq_mem [IQ_DEPTH];
  logic [IQ_AW-1:0]  iq_wptr, iq_rptr;
  logic [IQ_AW:0]    iq_cnt, iq_cnt_nx;
  logic              end_seen;

  logic [IDX_W-1:0]  quo;
  logic [REM_W-1:0]  rem, rem_sh, rem_nx;
  logic              rem_ge;
  logic [STEP_W-1:0] step;

  logic [31:0]       rb_mem [DEPTH];
  logic [AW-1:0]     rb_wptr, rb_rptr, rb_rptr_nx;
  logic [CNT_W-1:0]  rb_cnt_nx, rb_remain;
  logic [15:0]       x_pix, y_pix;
  logic [31:0]       wr_data, head_nx;

  logic cap_ok, in_range, iq_full, div_start, iq_push, iq_drop, range_hit;
  logic rb_full, rb_pop, rb_push, rb_ovf, is_dup, busy_nx;

  // Input capture; the divider takes the queue head on entry to DIV, so the
  // queue holds IQ_DEPTH positions waiting behind the one being converted.
  always_comb begin
    cap_ok    = iPos_valid && !end_seen &&
                (state == S_COLLECT || state == S_DIV || state == S_WR);
    in_range  = {1'b0, iPosition} < MAP_SIZE;
    iq_full   = iq_cnt == (IQ_AW+1)'(IQ_DEPTH);
    div_start = (state == S_COLLECT) && (iq_cnt != '0);
    iq_push   = cap_ok && in_range && (!iq_full || div_start);
    iq_drop   = cap_ok && in_range && iq_full && !div_start;
    range_hit = cap_ok && !in_range;
    iq_cnt_nx = iq_cnt + (IQ_AW+1)'(iq_push) - (IQ_AW+1)'(div_start);
  end

  // One restoring-division step per cycle; quo shifts the dividend out and the quotient in.
  always_comb begin
    rem_sh  = {rem[REM_W-2:0], quo[IDX_W-1]};
    rem_ge  = rem_sh >= DIVISOR;
    rem_nx  = rem_ge ? rem_sh - DIVISOR : rem_sh;
    x_pix   = (16'(rem) << SCALE_SHIFT) + 16'(OFFSET);
    y_pix   = (16'(quo) << SCALE_SHIFT) + 16'(OFFSET);
    wr_data = {x_pix, y_pix};
  end

`ifdef DUP_SUPPRESS_EN
  logic [31:0] last_data;
  logic        last_vld;

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      last_data <= '0;
      last_vld  <= 1'b0;
    end else if (iStart) begin
      last_data <= '0;
      last_vld  <= 1'b0;
    end else if (rb_push) begin
      last_data <= wr_data;
      last_vld  <= 1'b1;
    end
  end

  assign is_dup = last_vld && (last_data == wr_data);
`else
  assign is_dup = 1'b0;
`endif

  // Result buffer bookkeeping; a same-cycle pop frees the slot the push needs.
  always_comb begin
    rb_pop     = iRd && (oCount != '0);
    rb_full    = oCount == CNT_W'(DEPTH);
    rb_push    = (state == S_WR) && !is_dup && (!rb_full || rb_pop);
    rb_ovf     = (state == S_WR) && !is_dup && rb_full && !rb_pop;
    rb_remain  = oCount - CNT_W'(rb_pop);
    rb_cnt_nx  = rb_remain + CNT_W'(rb_push);
    rb_rptr_nx = rb_rptr + AW'(rb_pop);
    if (rb_cnt_nx == '0)      head_nx = '0;
    else if (rb_remain == '0) head_nx = wr_data;
    else                      head_nx = rb_mem[rb_rptr_nx];
    busy_nx    = div_start || (state == S_DIV) || (iq_cnt_nx != '0);
  end

  always_ff @(posedge iClk) begin
    if (iq_push) iq_mem[iq_wptr] <= iPosition;
    if (rb_push) rb_mem[rb_wptr] <= wr_data;
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state      <= S_IDLE;
      iq_wptr    <= '0;
      iq_rptr    <= '0;
      iq_cnt     <= '0;
      end_seen   <= 1'b0;
      quo        <= '0;
      rem        <= '0;
      step       <= '0;
      rb_wptr    <= '0;
      rb_rptr    <= '0;
      oCount     <= '0;
      oEmpty     <= 1'b1;
      oData      <= '0;
      oBusy      <= 1'b0;
      oDone      <= 1'b0;
      oOverflow  <= 1'b0;
      oRange_err <= 1'b0;
    end else if (iStart) begin
      state      <= S_COLLECT;
      iq_wptr    <= '0;
      iq_rptr    <= '0;
      iq_cnt     <= '0;
      end_seen   <= 1'b0;
      quo        <= '0;
      rem        <= '0;
      step       <= '0;
      rb_wptr    <= '0;
      rb_rptr    <= '0;
      oCount     <= '0;
      oEmpty     <= 1'b1;
      oData      <= '0;
      oBusy      <= 1'b0;
      oDone      <= 1'b0;
      oOverflow  <= 1'b0;
      oRange_err <= 1'b0;
    end else begin
      if (iq_push)   iq_wptr <= iq_wptr + IQ_AW'(1);
      if (div_start) iq_rptr <= iq_rptr + IQ_AW'(1);
      iq_cnt <= iq_cnt_nx;
      if (iEnd && state != S_IDLE) end_seen <= 1'b1;

      if (rb_push) rb_wptr <= rb_wptr + AW'(1);
      rb_rptr    <= rb_rptr_nx;
      oCount     <= rb_cnt_nx;
      oEmpty     <= rb_cnt_nx == '0;
      oData      <= head_nx;
      oBusy      <= busy_nx;
      oOverflow  <= oOverflow | iq_drop | rb_ovf;
      oRange_err <= oRange_err | range_hit;

      case (state)
        S_COLLECT: begin
          if (div_start) begin
            quo   <= iq_mem[iq_rptr];
            rem   <= '0;
            step  <= '0;
            state <= S_DIV;
          end else if (end_seen) begin
            state <= S_DONE;
            oDone <= 1'b1;
          end
        end
        S_DIV: begin
          quo  <= {quo[IDX_W-2:0], rem_ge};
          rem  <= rem_nx;
          step <= step + STEP_W'(1);
          if (step == STEP_W'(IDX_W - 1)) state <= S_WR;
        end
        S_WR:    state <= S_COLLECT;
        default: ;
      endcase
    end
  end

endmodule
